// File: rtl/eth_txbuf_pkg.sv
// Shared types and constants for the Ethernet TX buffer reader.
package eth_txbuf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned FIFO_DEPTH = 2;

  localparam logic [1:0] KEEP_BOTH = 2'b11;
  localparam logic [1:0] KEEP_LOW  = 2'b01;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  keep;
    logic        last;
  } beat_t;

endpackage

// File: rtl/eth_txbuf_fifo2.sv
// Two-entry beat FIFO with registered output and synchronous flush.
module eth_txbuf_fifo2
  import eth_txbuf_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       flush_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  beat_t      in_data_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output beat_t      out_data_o,
  output logic [1:0] count_o
);

  beat_t      mem_q [FIFO_DEPTH];
  beat_t      mem_d [FIFO_DEPTH];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       push, pop;

  assign in_ready_o  = (count_q != 2'(FIFO_DEPTH));
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = mem_q[rd_ptr_q];
  assign count_o     = count_q;
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = in_data_i;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/eth_txbuf_reader.sv
// Streams a frame from the halfword TX buffer onto an AXI-Stream master port.
// Define ETH_TXBUF_STATS_EN to enable the completed-frame counter on frame_cnt_o.
module eth_txbuf_reader
  import eth_txbuf_pkg::*;
#(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned LEN_W  = 12
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [1:0]        mem_we_o,
  input  logic [15:0]       mem_rdata_i,
  output logic [15:0]       m_tdata_o,
  output logic [1:0]        m_tkeep_o,
  output logic              m_tlast_o,
  output logic              m_tvalid_o,
  input  logic              m_tready_i,
  output logic [15:0]       frame_cnt_o
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  reads_left_q, reads_left_d;
  logic              odd_q, odd_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        inflight_keep_q, inflight_keep_d;
  logic              inflight_last_q, inflight_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              active, flush, pop, issue, last_rd;
  logic [1:0]        fifo_count, occ_after_pop;
  logic              fifo_in_ready, fifo_in_valid, fifo_out_valid;
  beat_t             fifo_in, fifo_out;

  assign active        = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign flush         = active && abort_i;
  assign pop           = fifo_out_valid && m_tready_i;
  assign last_rd       = (reads_left_q == LEN_W'(1));
  // A beat leaving this cycle frees its slot, so one read per cycle can be sustained.
  assign occ_after_pop = fifo_count - {1'b0, pop};
  assign issue         = (state_q == ST_FETCH) && !abort_i &&
                         ((occ_after_pop + {1'b0, inflight_q}) < 2'(FIFO_DEPTH));

  assign fifo_in_valid = inflight_q && fifo_in_ready;
  assign fifo_in.data  = mem_rdata_i;
  assign fifo_in.keep  = inflight_keep_q;
  assign fifo_in.last  = inflight_last_q;

  eth_txbuf_fifo2 u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush),
    .in_valid_i  (fifo_in_valid),
    .in_ready_o  (fifo_in_ready),
    .in_data_i   (fifo_in),
    .out_valid_o (fifo_out_valid),
    .out_ready_i (m_tready_i),
    .out_data_o  (fifo_out),
    .count_o     (fifo_count)
  );

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    reads_left_d    = reads_left_q;
    odd_d           = odd_q;
    inflight_d      = issue;
    inflight_keep_d = (last_rd && odd_q) ? KEEP_LOW : KEEP_BOTH;
    inflight_last_d = last_rd;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          addr_d       = base_i;
          reads_left_d = (len_i >> 1) + {{(LEN_W-1){1'b0}}, len_i[0]};
          odd_d        = len_i[0];
          state_d      = (len_i != '0) ? ST_FETCH : ST_DONE;
        end
      end
      ST_FETCH: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (issue) begin
          addr_d       = addr_q + 1'b1;
          reads_left_d = reads_left_q - 1'b1;
          if (last_rd) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (pop && fifo_out.last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_FETCH) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      reads_left_q    <= '0;
      odd_q           <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_keep_q <= 2'b00;
      inflight_last_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      reads_left_q    <= reads_left_d;
      odd_q           <= odd_d;
      inflight_q      <= inflight_d;
      inflight_keep_q <= inflight_keep_d;
      inflight_last_q <= inflight_last_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign mem_en_o   = issue;
  assign mem_addr_o = addr_q;
  assign mem_we_o   = 2'b00;
  assign m_tvalid_o = fifo_out_valid;
  assign m_tdata_o  = fifo_out.data;
  assign m_tkeep_o  = fifo_out.keep;
  assign m_tlast_o  = fifo_out.last;

`ifdef ETH_TXBUF_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (state_q == ST_DONE) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_cnt_q <= 16'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt_o = frame_cnt_q;
`else
  assign frame_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_eth_txbuf_reader.sv
// Scoreboard testbench for eth_txbuf_reader; honours ETH_TXBUF_STATS_EN for counter expectations.
module tb_eth_txbuf_reader;
  import eth_txbuf_pkg::*;

  localparam int ADDR_W = 11;
  localparam int LEN_W  = 12;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              start_i = 1'b0;
  logic [ADDR_W-1:0] base_i = '0;
  logic [LEN_W-1:0]  len_i = '0;
  logic              abort_i = 1'b0;
  logic              busy_o, done_o, mem_en_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [1:0]        mem_we_o;
  logic [15:0]       mem_rdata_i = 16'hDEAD;
  logic [15:0]       m_tdata_o;
  logic [1:0]        m_tkeep_o;
  logic              m_tlast_o, m_tvalid_o;
  logic              m_tready_i = 1'b1;
  logic [15:0]       frame_cnt_o;

  int    n_checks = 0;
  int    n_fail = 0;
  int    exp_frames = 0;
  beat_t exp_q[$];
  bit    pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  eth_txbuf_reader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .base_i      (base_i),
    .len_i       (len_i),
    .abort_i     (abort_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .mem_en_o    (mem_en_o),
    .mem_addr_o  (mem_addr_o),
    .mem_we_o    (mem_we_o),
    .mem_rdata_i (mem_rdata_i),
    .m_tdata_o   (m_tdata_o),
    .m_tkeep_o   (m_tkeep_o),
    .m_tlast_o   (m_tlast_o),
    .m_tvalid_o  (m_tvalid_o),
    .m_tready_i  (m_tready_i),
    .frame_cnt_o (frame_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [15:0] mem_word(input logic [ADDR_W-1:0] a);
    return {5'h15, a};
  endfunction

  // Buffer model: one-cycle read latency, garbage when not enabled.
  always @(posedge clk_i) begin
    mem_rdata_i <= mem_en_o ? mem_word(mem_addr_o) : 16'hDEAD;
  end

  function automatic logic [15:0] exp_cnt();
`ifdef ETH_TXBUF_STATS_EN
    return 16'(exp_frames);
`else
    return 16'd0;
`endif
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_ctrl"}, 32'({busy_o, done_o, mem_en_o, mem_we_o, m_tvalid_o, m_tkeep_o, m_tlast_o}), 32'd0);
    check_output({tag, "_addr_data"}, 32'({mem_addr_o, m_tdata_o}), 32'd0);
    check_output({tag, "_frame_cnt"}, 32'(frame_cnt_o), 32'd0);
  endtask

  task automatic push_frame(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] l);
    int n;
    beat_t e;
    logic [ADDR_W-1:0] a;
    n = (int'(l) + 1) / 2;
    a = b;
    for (int i = 0; i < n; i++) begin
      e.data = mem_word(a);
      e.last = (i == n - 1);
      e.keep = (e.last && l[0]) ? 2'b01 : 2'b11;
      exp_q.push_back(e);
      a = a + 1'b1;
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic apply_stimulus(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] l);
    push_frame(b, l);
    start_i = 1'b1;
    base_i  = b;
    len_i   = l;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
  endtask

  task automatic run_until_done(input string tag, input bit toggle);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (toggle) m_tready_i = pat[i % 4];
      @(negedge clk_i);
      if (done_o) got = 1'b1;
      @(posedge clk_i);
      #1;
    end
    m_tready_i = 1'b1;
    check_output({tag, "_done_seen"}, 32'(got), 32'd1);
    exp_frames++;
    check_output({tag, "_frame_cnt"}, 32'(frame_cnt_o), 32'(exp_cnt()));
    check_output({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_frame(input string tag, input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] l, input bit toggle);
    apply_stimulus(b, l);
    @(negedge clk_i);
    check_output({tag, "_first_read"}, 32'({mem_en_o, mem_addr_o}), 32'({1'b1, b}));
    @(posedge clk_i);
    #1;
    run_until_done(tag, toggle);
  endtask

  // Monitor: pops the scoreboard on every handshake, checks stall stability and read credit.
  int    outst = 0;
  bit    prev_stall = 1'b0;
  beat_t prev_beat = '0;
  always @(negedge clk_i) begin
    beat_t act;
    beat_t req;
    bit    hs;
    act.data = m_tdata_o;
    act.keep = m_tkeep_o;
    act.last = m_tlast_o;
    hs = m_tvalid_o && m_tready_i;
    if (!rst_ni) begin
      outst = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_output("stall_valid", 32'(m_tvalid_o), 32'd1);
        check_output("stall_stable", 32'(act), 32'(prev_beat));
      end
      if (hs) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_beat: actual 0x%0h required none", act);
        end else begin
          req = exp_q.pop_front();
          check_output("beat", 32'(act), 32'(req));
        end
      end
      if (abort_i) begin
        outst = 0;
      end else begin
        if (mem_en_o) outst++;
        if (hs) outst--;
      end
      if (mem_en_o) check_output("outstanding_le_2", 32'(outst <= 2), 32'd1);
      prev_stall = m_tvalid_o && !m_tready_i && !abort_i;
      prev_beat  = act;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: actual running required finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    $display("[TB] reset");
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_all_zero("reset");
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    $display("[TB] len=8 base=0x010, with start held while busy");
    apply_stimulus(11'h010, 12'd8);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_i);
      check_output("t1_ctrl", 32'({mem_en_o, busy_o, m_tvalid_o, m_tlast_o, done_o}),
                   32'({(k <= 4), (k <= 6), (k >= 3 && k <= 6), (k == 6), (k == 7)}));
      if (k <= 4) check_output("t1_addr", 32'(mem_addr_o), 32'(16 + k - 1));
      if (k >= 3 && k <= 6) check_output("t1_keep", 32'(m_tkeep_o), 32'd3);
      @(posedge clk_i);
      #1;
      if (k == 1) begin
        start_i = 1'b1;
        base_i  = 11'h300;
        len_i   = 12'd2;
      end
      if (k == 7) start_i = 1'b0;
    end
    exp_frames++;
    check_output("t1_frame_cnt", 32'(frame_cnt_o), 32'(exp_cnt()));
    check_output("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] len=5 base=0x7FF wrap");
    run_frame("t2", 11'h7FF, 12'd5, 1'b0);

    $display("[TB] len=6 with tready pattern 1,0,0,1");
    run_frame("t3", 11'h123, 12'd6, 1'b1);

    $display("[TB] len=0");
    apply_stimulus(11'h055, 12'd0);
    @(negedge clk_i);
    check_output("t4_done_cycle", 32'({done_o, busy_o, m_tvalid_o, mem_en_o}), 32'b1000);
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    check_output("t4_after_done", 32'({done_o, busy_o, m_tvalid_o}), 32'd0);
    exp_frames++;
    check_output("t4_frame_cnt", 32'(frame_cnt_o), 32'(exp_cnt()));
    @(posedge clk_i);
    #1;

    $display("[TB] len=20 aborted on beat 3");
    apply_stimulus(11'h200, 12'd20);
    repeat (4) @(posedge clk_i);
    #1;
    abort_i = 1'b1;
    @(negedge clk_i);
    check_output("t5_beat3_valid", 32'(m_tvalid_o), 32'd1);
    @(posedge clk_i);
    #1;
    abort_i = 1'b0;
    check_output("t5_beats_left", 32'(exp_q.size()), 32'd7);
    exp_q.delete();
    push_frame(11'h100, 12'd4);
    start_i = 1'b1;
    base_i  = 11'h100;
    len_i   = 12'd4;
    @(negedge clk_i);
    check_output("t5_after_abort", 32'({m_tvalid_o, busy_o, done_o, mem_en_o}), 32'd0);
    check_output("t5_frame_cnt_kept", 32'(frame_cnt_o), 32'(exp_cnt()));
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    @(negedge clk_i);
    check_output("t5_restart_read", 32'({mem_en_o, mem_addr_o}), 32'({1'b1, 11'h100}));
    @(posedge clk_i);
    #1;
    run_until_done("t5_restart", 1'b0);

    $display("[TB] reset mid-frame");
    apply_stimulus(11'h3F0, 12'd10);
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    #1;
    check_all_zero("t6_reset");
    exp_q.delete();
    exp_frames = 0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    run_frame("t6_after", 11'h020, 12'd3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
